// File: rtl/vx_dmem_pkg.sv
// ---------------------------------------------------------------------------
// vx_dmem_pkg
// Shared definitions for the dmem response collector:
//   - TileLink D-channel opcode constants
//   - collector FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package vx_dmem_pkg;

    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/vx_dmem_lane_fifo.sv
// ---------------------------------------------------------------------------
// vx_dmem_lane_fifo
// Synchronous single-clock FIFO holding {source,data} load-response beats for
// one lane. DEPTH must be a power of two (>= 2).
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (empties the FIFO)
//   i_push   in   write i_data this edge (caller guarantees !o_full || i_pop)
//   i_data   in   entry to write
//   i_pop    in   drop the head entry this edge (caller guarantees !o_empty)
//   o_data   out  head entry (meaningless while o_empty)
//   o_full   out  DEPTH entries stored
//   o_empty  out  no entries stored
// ---------------------------------------------------------------------------
module vx_dmem_lane_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (i_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: contents are only observed when not empty.
    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/vx_dmem_rsp_collector.sv
// ---------------------------------------------------------------------------
// vx_dmem_rsp_collector
// Collects per-lane TileLink D-channel responses, drops AccessAcks, buffers
// load data per lane and groups lanes whose head beats share a source tag into
// one dcache response. Tracks per-lane outstanding requests for A-channel
// credit.
//
// Optional build macro: VX_DMEM_RSP_COALESCE_EN
//   defined   : IDLE -> WAIT -> EMIT; WAIT holds up to WAIT_CYCLES cycles so
//               late lanes with outstanding requests can join the group.
//   undefined : IDLE -> EMIT directly (WAIT unreachable).
//
// Handshakes: a D beat transfers on an edge where dmem_d_valid[i] and
// dmem_d_ready[i] are both 1; a group transfers on an edge where
// dcache_rsp_valid and dcache_rsp_ready are both 1, and the group outputs are
// held stable while valid is high and ready is low.
//
// Ports:
//   clock, reset_n     clock / asynchronous active-low reset
//   dmem_d_*           per-lane D channel (valid/opcode/source/data in, ready out)
//   dmem_a_fire        per-lane A handshake completed (new outstanding request)
//   lane_credit        per-lane permission to issue another A request
//   dcache_rsp_*       grouped response (valid/tmask/data/tag out, ready in)
//   idle               nothing outstanding, nothing buffered, FSM in IDLE
// The FSM state is held in r_state for observation.
// ---------------------------------------------------------------------------
module vx_dmem_rsp_collector
    import vx_dmem_pkg::*;
#(
    parameter int NUM_LANES       = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_WIDTH       = 10,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int WAIT_CYCLES     = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_LANES-1:0]            dmem_d_valid,
    input  logic [3*NUM_LANES-1:0]          dmem_d_opcode,
    input  logic [TAG_WIDTH*NUM_LANES-1:0]  dmem_d_source,
    input  logic [DATA_WIDTH*NUM_LANES-1:0] dmem_d_data,
    output logic [NUM_LANES-1:0]            dmem_d_ready,
    input  logic [NUM_LANES-1:0]            dmem_a_fire,
    output logic [NUM_LANES-1:0]            lane_credit,
    output logic                            dcache_rsp_valid,
    output logic [NUM_LANES-1:0]            dcache_rsp_tmask,
    output logic [DATA_WIDTH*NUM_LANES-1:0] dcache_rsp_data,
    output logic [TAG_WIDTH-1:0]            dcache_rsp_tag,
    input  logic                            dcache_rsp_ready,
    output logic                            idle
);

    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;
`ifdef VX_DMEM_RSP_COALESCE_EN
    localparam int WAIT_W  = $clog2(WAIT_CYCLES + 1);
`endif

    rsp_state_e                      r_state;
    logic                            r_valid;
    logic [NUM_LANES-1:0]            r_tmask;
    logic [DATA_WIDTH*NUM_LANES-1:0] r_data;
    logic [TAG_WIDTH-1:0]            r_tag;
`ifdef VX_DMEM_RSP_COALESCE_EN
    logic [WAIT_W-1:0]               r_wait;
    logic                            w_all_match;
`endif

    logic [NUM_LANES-1:0]            w_empty;
    logic [NUM_LANES-1:0]            w_pop;
    logic [NUM_LANES-1:0]            w_ack_acc;
    logic [NUM_LANES-1:0]            w_match;
    logic [NUM_LANES-1:0]            w_cnt_zero;
    logic [TAG_WIDTH*NUM_LANES-1:0]  w_head_src;
    logic [DATA_WIDTH*NUM_LANES-1:0] w_match_data;
    logic [TAG_WIDTH-1:0]            w_first_tag;
    logic [TAG_WIDTH-1:0]            w_cmp_tag;

    // -----------------------------------------------------------------------
    // Per-lane datapath: D-channel acceptance, FIFO, outstanding counter
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [2:0]         w_opcode;
        logic               w_is_data;
        logic               w_fifo_ready;
        logic               w_push;
        logic               w_full;
        logic [ENTRY_W-1:0] w_wr_entry;
        logic [ENTRY_W-1:0] w_head;
        logic [CNT_W-1:0]   r_cnt;
        logic               w_inc;
        logic [CNT_W:0]     w_sum;
        logic [CNT_W:0]     w_dec;

        assign w_opcode     = dmem_d_opcode[3*i +: 3];
        assign w_ack_acc[i] = reset_n && dmem_d_valid[i] && (w_opcode == TL_D_ACCESS_ACK);
        assign w_is_data    = dmem_d_valid[i] && (w_opcode != TL_D_ACCESS_ACK);
        assign w_pop[i]     = (r_state == ST_EMIT) && dcache_rsp_ready && r_tmask[i];
        // A pop on the same edge frees a slot, so a full FIFO can still accept.
        assign w_fifo_ready = !w_full || w_pop[i];
        assign w_push       = reset_n && w_is_data && w_fifo_ready;

        assign dmem_d_ready[i] = w_ack_acc[i] || w_push;

        assign w_wr_entry = {dmem_d_source[TAG_WIDTH*i +: TAG_WIDTH],
                             dmem_d_data[DATA_WIDTH*i +: DATA_WIDTH]};

        vx_dmem_lane_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .i_push  (w_push),
            .i_data  (w_wr_entry),
            .i_pop   (w_pop[i]),
            .o_data  (w_head),
            .o_full  (w_full),
            .o_empty (w_empty[i])
        );

        assign w_head_src[TAG_WIDTH*i +: TAG_WIDTH] = w_head[ENTRY_W-1 -: TAG_WIDTH];
        assign w_match[i] = !w_empty[i] && (w_head[ENTRY_W-1 -: TAG_WIDTH] == w_cmp_tag);
        assign w_match_data[DATA_WIDTH*i +: DATA_WIDTH] =
            w_match[i] ? w_head[DATA_WIDTH-1:0] : '0;

        // Outstanding counter: +1 on a_fire (saturating at the limit), -1 for
        // each of AccessAck accept and FIFO pop; both can happen in one cycle.
        assign w_inc = dmem_a_fire[i] && (r_cnt < CNT_W'(MAX_OUTSTANDING));
        assign w_sum = {1'b0, r_cnt} + {{CNT_W{1'b0}}, w_inc};
        assign w_dec = {{(CNT_W-1){1'b0}}, w_ack_acc[i] & w_pop[i], w_ack_acc[i] ^ w_pop[i]};

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= (w_sum >= w_dec) ? CNT_W'(w_sum - w_dec) : '0;
            end
        end

        assign lane_credit[i] = (r_cnt < CNT_W'(MAX_OUTSTANDING));
        assign w_cnt_zero[i]  = (r_cnt == '0);

`ifndef SYNTHESIS
        always @(posedge clock) begin
            if (reset_n && dmem_a_fire[i]) begin
                assert (r_cnt < CNT_W'(MAX_OUTSTANDING))
                    else $error("lane %0d: a_fire with outstanding counter at limit", i);
            end
        end
`endif
    end

    // Tag of the lowest-indexed non-empty lane.
    always_comb begin
        w_first_tag = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (!w_empty[k]) w_first_tag = w_head_src[TAG_WIDTH*k +: TAG_WIDTH];
        end
    end

`ifdef VX_DMEM_RSP_COALESCE_EN
    // While waiting, lanes are matched against the tag latched on entry.
    assign w_cmp_tag   = (r_state == ST_WAIT) ? r_tag : w_first_tag;
    // Every lane still expecting a response already shows a matching head.
    assign w_all_match = &(w_cnt_zero | w_match);
`else
    assign w_cmp_tag   = w_first_tag;
`endif

    // -----------------------------------------------------------------------
    // Grouping FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_tmask <= '0;
            r_data  <= '0;
            r_tag   <= '0;
`ifdef VX_DMEM_RSP_COALESCE_EN
            r_wait  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!(&w_empty)) begin
                        r_tag <= w_first_tag;
`ifdef VX_DMEM_RSP_COALESCE_EN
                        r_state <= ST_WAIT;
                        r_wait  <= WAIT_W'(WAIT_CYCLES);
`else
                        // The first lane always matches its own tag, so the
                        // mask latched here is never zero.
                        r_state <= ST_EMIT;
                        r_valid <= 1'b1;
                        r_tmask <= w_match;
                        r_data  <= w_match_data;
`endif
                    end
                end
                ST_WAIT: begin
`ifdef VX_DMEM_RSP_COALESCE_EN
                    // Nothing pops outside EMIT, so the lane that set r_tag
                    // still matches and the latched mask is non-zero.
                    if (w_all_match || (r_wait <= WAIT_W'(1))) begin
                        r_state <= ST_EMIT;
                        r_valid <= 1'b1;
                        r_tmask <= w_match;
                        r_data  <= w_match_data;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                ST_EMIT: begin
                    if (dcache_rsp_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_tmask <= '0;
                        r_data  <= '0;
                        r_tag   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dcache_rsp_valid = r_valid;
    assign dcache_rsp_tmask = r_tmask;
    assign dcache_rsp_data  = r_data;
    assign dcache_rsp_tag   = r_tag;
    assign idle             = (r_state == ST_IDLE) && (&w_empty) && (&w_cnt_zero);

endmodule

// File: tb/tb_vx_dmem_rsp_collector.sv
module tb_vx_dmem_rsp_collector;

  localparam int NL = 4;
  localparam int DW = 32;
  localparam int TW = 10;
  localparam int WAIT_CYCLES = 16;
  localparam int W = NL + NL * DW + TW;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NL-1:0]     dmem_d_valid;
  logic [3*NL-1:0]   dmem_d_opcode;
  logic [TW*NL-1:0]  dmem_d_source;
  logic [DW*NL-1:0]  dmem_d_data;
  logic [NL-1:0]     dmem_d_ready;
  logic [NL-1:0]     dmem_a_fire;
  logic [NL-1:0]     lane_credit;
  logic              dcache_rsp_valid;
  logic [NL-1:0]     dcache_rsp_tmask;
  logic [DW*NL-1:0]  dcache_rsp_data;
  logic [TW-1:0]     dcache_rsp_tag;
  logic              dcache_rsp_ready;
  logic              idle;

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];

  vx_dmem_rsp_collector #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .FIFO_DEPTH(4), .MAX_OUTSTANDING(8), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .dmem_d_valid(dmem_d_valid), .dmem_d_opcode(dmem_d_opcode),
    .dmem_d_source(dmem_d_source), .dmem_d_data(dmem_d_data),
    .dmem_d_ready(dmem_d_ready), .dmem_a_fire(dmem_a_fire),
    .lane_credit(lane_credit), .dcache_rsp_valid(dcache_rsp_valid),
    .dcache_rsp_tmask(dcache_rsp_tmask), .dcache_rsp_data(dcache_rsp_data),
    .dcache_rsp_tag(dcache_rsp_tag), .dcache_rsp_ready(dcache_rsp_ready),
    .idle(idle)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled at
  // the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_beat(input int lane, input logic [2:0] op,
                          input logic [TW-1:0] src, input logic [DW-1:0] dat);
    dmem_d_valid[lane] = 1'b1;
    dmem_d_opcode[lane*3 +: 3] = op;
    dmem_d_source[lane*TW +: TW] = src;
    dmem_d_data[lane*DW +: DW] = dat;
  endtask

  // ---------------- scoreboard monitor ----------------
  // A group is consumed on the next rising edge when valid and ready are high.
  always @(negedge clock) begin
    if (reset_n && dcache_rsp_valid && dcache_rsp_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected: got tmask=%h tag=%h data=%h, required no response",
                 dcache_rsp_tmask, dcache_rsp_tag, dcache_rsp_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({dcache_rsp_tmask, dcache_rsp_data, dcache_rsp_tag} !== e)
          $display("FAIL rsp_compare: got %h, required %h",
                   {dcache_rsp_tmask, dcache_rsp_data, dcache_rsp_tag}, e);
        else
          n_pass++;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    dmem_d_valid = '1;
    dmem_d_opcode = {NL{3'b001}};
    dmem_d_source = '0;
    dmem_d_data = '0;
    dmem_a_fire = '0;
    dcache_rsp_ready = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (dmem_d_ready !== 4'h0) $display("FAIL reset_d_ready: got %h, required 0", dmem_d_ready);
    else n_pass++;
    n_checks++;
    if (dcache_rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", dcache_rsp_valid);
    else n_pass++;
    n_checks++;
    if ({dcache_rsp_tmask, dcache_rsp_tag} !== '0)
      $display("FAIL reset_tmask_tag: got %h/%h, required 0/0", dcache_rsp_tmask, dcache_rsp_tag);
    else n_pass++;
    n_checks++;
    if (dcache_rsp_data !== '0) $display("FAIL reset_data: got %h, required 0", dcache_rsp_data);
    else n_pass++;
    n_checks++;
    if (lane_credit !== 4'hF) $display("FAIL reset_credit: got %h, required f", lane_credit);
    else n_pass++;
    n_checks++;
    if (idle !== 1'b1) $display("FAIL reset_idle: got %b, required 1", idle);
    else n_pass++;
    step();
    dmem_d_valid = '0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_group();
    step();
    dmem_a_fire = 4'hF;
    step();
    dmem_a_fire = '0;
    for (int i = 0; i < NL; i++) set_beat(i, 3'd1, 10'h005, 32'h10 + i);
    exp_q.push_back({4'hF, 32'h13, 32'h12, 32'h11, 32'h10, 10'h005});
    @(negedge clock);
    n_checks++;
    if (dmem_d_ready !== 4'hF) $display("FAIL group_d_ready: got %h, required f", dmem_d_ready);
    else n_pass++;
    step();  // beats written on this edge
    dmem_d_valid = '0;
    @(negedge clock);
    n_checks++;
    if (dcache_rsp_valid !== 1'b0) $display("FAIL group_early_valid: got %b, required 0", dcache_rsp_valid);
    else n_pass++;
    step();
    @(negedge clock);
    n_checks++;
    if (dcache_rsp_valid !== 1'b1) $display("FAIL group_latency_valid: got %b, required 1", dcache_rsp_valid);
    else n_pass++;
    step();  // handshake edge
    @(negedge clock);
    n_checks++;
    if ({dcache_rsp_valid, idle, lane_credit} !== {1'b0, 1'b1, 4'hF})
      $display("FAIL group_after: got valid=%b idle=%b credit=%h, required 0 1 f",
               dcache_rsp_valid, idle, lane_credit);
    else n_pass++;
  endtask

  task automatic test_ack();
    step();
    dmem_a_fire = 4'b0100;
    step();
    dmem_a_fire = '0;
    set_beat(2, 3'd0, 10'h000, 32'h0);
    @(negedge clock);
    n_checks++;
    if (dmem_d_ready !== 4'b0100) $display("FAIL ack_d_ready: got %h, required 4", dmem_d_ready);
    else n_pass++;
    n_checks++;
    if (idle !== 1'b0) $display("FAIL ack_busy: got idle=%b, required 0", idle);
    else n_pass++;
    step();
    dmem_d_valid = '0;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if ({dcache_rsp_valid, idle} !== 2'b01)
        $display("FAIL ack_after: got valid=%b idle=%b, required 0 1", dcache_rsp_valid, idle);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_credit();
    for (int k = 0; k < 8; k++) begin
      step();
      dmem_a_fire = 4'b0010;
    end
    step();
    dmem_a_fire = '0;
    @(negedge clock);
    n_checks++;
    if (lane_credit !== 4'b1101) $display("FAIL credit_limit: got %h, required d", lane_credit);
    else n_pass++;
    step();
    set_beat(1, 3'd0, 10'h000, 32'h0);
    step();
    @(negedge clock);
    n_checks++;
    if (lane_credit !== 4'hF) $display("FAIL credit_return: got %h, required f", lane_credit);
    else n_pass++;
    repeat (6) step();
    dmem_d_valid = '0;
    @(negedge clock);
    n_checks++;
    if (idle !== 1'b0) $display("FAIL credit_one_left: got idle=%b, required 0", idle);
    else n_pass++;
    step();
    set_beat(1, 3'd0, 10'h000, 32'h0);
    step();
    dmem_d_valid = '0;
    @(negedge clock);
    n_checks++;
    if (idle !== 1'b1) $display("FAIL credit_drained: got idle=%b, required 1", idle);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [NL-1:0] m, g1, g2;
      logic [TW-1:0] t, t2;
      logic [TW-1:0] tg[NL];
      logic [DW-1:0] dt[NL];
      logic [NL*DW-1:0] d1, d2;
      int f;
      m = 4'($urandom_range(1, 15));
      t = TW'($urandom_range(0, 1000));
      for (int i = 0; i < NL; i++) begin
        tg[i] = ($urandom_range(0, 1) == 1) ? t + 10'd1 : t;
        dt[i] = $urandom;
      end
      f = 0;
      for (int i = NL - 1; i >= 0; i--) if (m[i]) f = i;
      g1 = '0; g2 = '0; d1 = '0; d2 = '0; t2 = '0;
      for (int i = 0; i < NL; i++) begin
        if (m[i]) begin
          if (tg[i] == tg[f]) begin
            g1[i] = 1'b1;
            d1[i*DW +: DW] = dt[i];
          end else begin
            g2[i] = 1'b1;
            d2[i*DW +: DW] = dt[i];
            t2 = tg[i];
          end
        end
      end
      step();
      dmem_a_fire = m;
      step();
      dmem_a_fire = '0;
      for (int i = 0; i < NL; i++) if (m[i]) set_beat(i, 3'd1, tg[i], dt[i]);
      exp_q.push_back({g1, d1, tg[f]});
      if (g2 != '0) exp_q.push_back({g2, d2, t2});
      step();
      dmem_d_valid = '0;
      for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL random_drain: %0d groups pending, required 0", exp_q.size());
      else n_pass++;
    end
    step();
    @(negedge clock);
    n_checks++;
    if (idle !== 1'b1) $display("FAIL random_idle: got %b, required 1", idle);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    dcache_rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      dmem_a_fire = 4'b0001;
    end
    step();
    dmem_a_fire = '0;
    for (int k = 0; k < 5; k++) begin
      set_beat(0, 3'd1, TW'(32'h20 + k), 32'hA0 + k);
      exp_q.push_back({4'b0001, 96'h0, 32'hA0 + k, TW'(32'h20 + k)});
      @(negedge clock);
      n_checks++;
      if (k < 4) begin
        if (dmem_d_ready[0] !== 1'b1) $display("FAIL bp_ready_beat%0d: got %b, required 1", k, dmem_d_ready[0]);
        else n_pass++;
        step();
      end else begin
        if (dmem_d_ready[0] !== 1'b0) $display("FAIL bp_ready_full: got %b, required 0", dmem_d_ready[0]);
        else n_pass++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      step();
      @(negedge clock);
      n_checks++;
      if ({dcache_rsp_valid, dcache_rsp_tmask, dcache_rsp_tag, dcache_rsp_data, dmem_d_ready[0]} !==
          {1'b1, 4'b0001, 10'h020, 96'h0, 32'hA0, 1'b0})
        $display("FAIL bp_hold_c%0d: got valid=%b tmask=%h tag=%h data=%h ready0=%b, required 1 1 020 a0 0",
                 c, dcache_rsp_valid, dcache_rsp_tmask, dcache_rsp_tag, dcache_rsp_data, dmem_d_ready[0]);
      else n_pass++;
    end
    step();
    dcache_rsp_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (dmem_d_ready[0] !== 1'b1) $display("FAIL bp_full_and_pop: got %b, required 1", dmem_d_ready[0]);
    else n_pass++;
    step();
    dmem_d_valid = '0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL bp_drain: %0d groups pending, required 0", exp_q.size());
    else n_pass++;
    step();
    @(negedge clock);
    n_checks++;
    if (idle !== 1'b1) $display("FAIL bp_idle: got %b, required 1", idle);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    dcache_rsp_ready = 1'b0;
    step();
    dmem_a_fire = 4'b0011;
    step();
    dmem_a_fire = '0;
    set_beat(0, 3'd1, 10'h003, 32'h55);
    set_beat(1, 3'd1, 10'h003, 32'h66);
    step();
    dmem_d_valid = '0;
    for (int c = 0; c < 10 && !dcache_rsp_valid; c++) @(negedge clock);
    n_checks++;
    if (dcache_rsp_valid !== 1'b1) $display("FAIL rmid_emit: got %b, required 1", dcache_rsp_valid);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({dcache_rsp_valid, dcache_rsp_tmask, idle, lane_credit} !== {1'b0, 4'h0, 1'b1, 4'hF})
      $display("FAIL rmid_async: got valid=%b tmask=%h idle=%b credit=%h, required 0 0 1 f",
               dcache_rsp_valid, dcache_rsp_tmask, idle, lane_credit);
    else n_pass++;
    step();
    step();
    reset_n = 1'b1;
    dcache_rsp_ready = 1'b1;
    repeat (4) step();
    @(negedge clock);
    n_checks++;
    if ({dcache_rsp_valid, idle} !== 2'b01)
      $display("FAIL rmid_flushed: got valid=%b idle=%b, required 0 1", dcache_rsp_valid, idle);
    else n_pass++;
  endtask

`ifdef VX_DMEM_RSP_COALESCE_EN
  task automatic test_coalesce_wait();
    step();
    dmem_a_fire = 4'b0011;
    step();
    dmem_a_fire = '0;
    set_beat(0, 3'd1, 10'h007, 32'h70);
    exp_q.push_back({4'b0011, 64'h0, 32'h71, 32'h70, 10'h007});
    step();
    dmem_d_valid = '0;
    for (int c = 1; c < 5; c++) begin
      @(negedge clock);
      n_checks++;
      if (dcache_rsp_valid !== 1'b0) $display("FAIL cw_early_c%0d: got %b, required 0", c, dcache_rsp_valid);
      else n_pass++;
      step();
    end
    set_beat(1, 3'd1, 10'h007, 32'h71);
    @(negedge clock);
    n_checks++;
    if (dcache_rsp_valid !== 1'b0) $display("FAIL cw_early_c5: got %b, required 0", dcache_rsp_valid);
    else n_pass++;
    step();
    dmem_d_valid = '0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL cw_drain: %0d groups pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_coalesce_timeout();
    int cnt;
    step();
    dmem_a_fire = 4'hF;
    step();
    dmem_a_fire = '0;
    for (int i = 0; i < 3; i++) set_beat(i, 3'd1, 10'h009, 32'h90 + i);
    exp_q.push_back({4'b0111, 32'h0, 32'h92, 32'h91, 32'h90, 10'h009});
    step();  // beats written on this edge
    dmem_d_valid = '0;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (dcache_rsp_valid) break;
      cnt++;
    end
    // One IDLE cycle, then WAIT_CYCLES cycles in WAIT.
    n_checks++;
    if (cnt != WAIT_CYCLES + 1) $display("FAIL ct_timeout: got %0d cycles, required %0d", cnt, WAIT_CYCLES + 1);
    else n_pass++;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL ct_drain: %0d groups pending, required 0", exp_q.size());
    else n_pass++;
    set_beat(3, 3'd0, 10'h000, 32'h0);
    step();
    dmem_d_valid = '0;
    @(negedge clock);
    n_checks++;
    if (idle !== 1'b1) $display("FAIL ct_idle: got %b, required 1", idle);
    else n_pass++;
  endtask
`endif

  // ---------------- sequence + final report ----------------
  initial begin
    dmem_d_valid = '0;
    dmem_d_opcode = '0;
    dmem_d_source = '0;
    dmem_d_data = '0;
    dmem_a_fire = '0;
    dcache_rsp_ready = 1'b0;
    reset_n = 1'b0;
    test_reset();
`ifdef VX_DMEM_RSP_COALESCE_EN
    test_coalesce_wait();
    test_coalesce_timeout();
`else
    test_group();
    test_random();
`endif
    test_ack();
    test_credit();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
